sdram_init: RTL and testbench



---
 rtl/sdram_init_if.sv | 20 ++
 rtl/sdram_init.sv | 179 +++++++++++++++++
 tb/tb_sdram_init.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_init_if.sv
// SDRAM command bus driven by the power-up sequencer.
// The master side drives it; the main controller samples it.
interface sdram_init_if #(
  parameter int ADDR_W = 13,
  parameter int BA_W   = 2
);
  logic              o_cke;
  logic [3:0]        o_cmd;
  logic [BA_W-1:0]   o_ba;
  logic [ADDR_W-1:0] o_addr;
  logic              o_init_done;

  modport master (
    output o_cke, o_cmd, o_ba, o_addr, o_init_done
  );

  modport slave (
    input o_cke, o_cmd, o_ba, o_addr, o_init_done
  );
endinterface

// File: rtl/sdram_init.sv
// SDRAM power-up sequencer: wait, PRECHARGE-ALL, N x AUTO-REFRESH,
// LOAD-MODE, then a sticky init-done flag.
module sdram_init #(
  parameter int T_POWERUP   = 10000,
  parameter int T_RP        = 2,
  parameter int T_RFC       = 7,
  parameter int T_MRD       = 2,
  parameter int REFRESH_NUM = 2,
  parameter int ADDR_W      = 13,
  parameter int BA_W        = 2,
  parameter logic [ADDR_W-1:0] MODE_REG = 'h032
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clk_locked,
  sdram_init_if.master bus
);

  localparam int CW = $clog2(T_POWERUP + 1);
  localparam int RW = $clog2(REFRESH_NUM + 1);

  localparam logic [CW-1:0] LD_PU  = CW'(T_POWERUP - 1);
  localparam logic [CW-1:0] LD_RP  = CW'(T_RP  > 1 ? T_RP  - 2 : 0);
  localparam logic [CW-1:0] LD_RFC = CW'(T_RFC > 1 ? T_RFC - 2 : 0);
  localparam logic [CW-1:0] LD_MRD = CW'(T_MRD > 1 ? T_MRD - 2 : 0);
  localparam logic [RW-1:0] REF_N  = RW'(REFRESH_NUM);

  localparam bit RP1  = (T_RP  == 1);
  localparam bit RFC1 = (T_RFC == 1);
  localparam bit MRD1 = (T_MRD == 1);

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_MRS = 4'b0000;

  localparam logic [ADDR_W-1:0] A_PALL = ADDR_W'(1 << 10);

  typedef enum logic [3:0] {
    S_IDLE,
    S_POWERUP,
    S_PRE,
    S_WAIT_RP,
    S_REF,
    S_WAIT_RFC,
    S_MRS,
    S_WAIT_MRD,
    S_DONE
  } state_t;

  logic              r_sync1;
  logic              r_locked;
  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [RW-1:0]     r_ref_cnt;
  logic              r_cke;
  logic [3:0]        r_cmd;
  logic [ADDR_W-1:0] r_addr;
  logic              r_done;

  state_t            w_nxt;
  state_t            w_rfc_exit;
  logic [CW-1:0]     w_cnt_nxt;
  logic [RW-1:0]     w_ref_nxt;
  logic [3:0]        w_cmd;
  logic [ADDR_W-1:0] w_addr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1  <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_sync1  <= i_clk_locked;
      r_locked <= r_sync1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_ref_cnt <= '0;
      r_cke     <= 1'b0;
      r_cmd     <= C_NOP;
      r_addr    <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ref_cnt <= w_ref_nxt;
      r_cke     <= (w_nxt != S_IDLE);
      r_cmd     <= w_cmd;
      r_addr    <= w_addr;
      r_done    <= (w_nxt == S_DONE);
    end
  end

  always_comb begin
    w_nxt      = r_state;
    w_cnt_nxt  = r_cnt;
    w_rfc_exit = (r_ref_cnt < REF_N) ? S_REF : S_MRS;
    if (r_cnt != '0) w_cnt_nxt = r_cnt - CW'(1);
    unique case (r_state)
      S_IDLE: begin
        if (r_locked) begin
          w_nxt     = S_POWERUP;
          w_cnt_nxt = LD_PU;
        end
      end
      S_POWERUP: begin
        if (r_cnt == '0) w_nxt = S_PRE;
      end
      S_PRE: begin
        w_nxt     = RP1 ? S_REF : S_WAIT_RP;
        w_cnt_nxt = LD_RP;
      end
      S_WAIT_RP: begin
        if (r_cnt == '0) w_nxt = S_REF;
      end
      S_REF: begin
        w_nxt     = RFC1 ? w_rfc_exit : S_WAIT_RFC;
        w_cnt_nxt = LD_RFC;
      end
      S_WAIT_RFC: begin
        if (r_cnt == '0) begin
          w_nxt     = w_rfc_exit;
          w_cnt_nxt = LD_RFC;
        end
      end
      S_MRS: begin
        w_nxt     = MRD1 ? S_DONE : S_WAIT_MRD;
        w_cnt_nxt = LD_MRD;
      end
      S_WAIT_MRD: begin
        if (r_cnt == '0) w_nxt = S_DONE;
      end
      S_DONE: w_nxt = S_DONE;
      default: w_nxt = S_IDLE;
    endcase
    // Lock loss aborts everything short of DONE, even a pending command
    if (!r_locked && r_state != S_IDLE && r_state != S_DONE) begin
      w_nxt     = S_IDLE;
      w_cnt_nxt = '0;
    end
  end

  always_comb begin
    w_ref_nxt = r_ref_cnt;
    if (w_nxt == S_IDLE)     w_ref_nxt = '0;
    else if (w_nxt == S_REF) w_ref_nxt = r_ref_cnt + RW'(1);
  end

  always_comb begin
    w_cmd  = C_NOP;
    w_addr = '0;
    unique case (1'b1)
      (w_nxt == S_PRE): begin
        w_cmd  = C_PRE;
        w_addr = A_PALL;
      end
      (w_nxt == S_REF): w_cmd = C_REF;
      (w_nxt == S_MRS): begin
        w_cmd  = C_MRS;
        w_addr = MODE_REG;
      end
      default: begin
        w_cmd  = C_NOP;
        w_addr = '0;
      end
    endcase
  end

  assign bus.o_cke       = r_cke;
  assign bus.o_cmd       = r_cmd;
  assign bus.o_ba        = '0;
  assign bus.o_addr      = r_addr;
  assign bus.o_init_done = r_done;

endmodule

// File: tb/tb_sdram_init.sv
// Scoreboard bench for sdram_init: two parameter sets, expected
// bus events queued by stimulus and matched by per-DUT monitors.
module tb_sdram_init;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] REF = 4'b0001;
  localparam logic [3:0] MRS = 4'b0000;
  localparam logic [12:0] A_PALL = 13'h400;
  localparam logic [12:0] A_MODE = 13'h032;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [12:0] addr;
    logic        cke;
    logic        done;
    int          cyc;
  } ev_t;

  logic clk;
  logic rst_a, lock_a, rst_b, lock_b;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  ev_t  qa[$];
  ev_t  qb[$];
  logic pc[2];
  logic pd[2];

  sdram_init_if #(.ADDR_W(13), .BA_W(2)) bus_a ();
  sdram_init_if #(.ADDR_W(13), .BA_W(2)) bus_b ();

  sdram_init #(
    .T_POWERUP(20), .T_RP(2), .T_RFC(7), .T_MRD(2),
    .REFRESH_NUM(2), .ADDR_W(13), .BA_W(2), .MODE_REG(13'h032)
  ) dut_a (
    .i_clk(clk), .i_rst(rst_a), .i_clk_locked(lock_a),
    .bus(bus_a.master)
  );

  sdram_init #(
    .T_POWERUP(5), .T_RP(1), .T_RFC(1), .T_MRD(1),
    .REFRESH_NUM(3), .ADDR_W(13), .BA_W(2), .MODE_REG(13'h032)
  ) dut_b (
    .i_clk(clk), .i_rst(rst_b), .i_clk_locked(lock_b),
    .bus(bus_b.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  function automatic int qsz(input int id);
    return (id == 0) ? qa.size() : qb.size();
  endfunction

  task automatic push(input int id, input logic [3:0] c,
                      input logic [12:0] a, input logic k,
                      input logic d, input int t);
    ev_t e;
    e.cmd = c; e.addr = a; e.cke = k; e.done = d; e.cyc = t;
    if (id == 0) qa.push_back(e);
    else         qb.push_back(e);
  endtask

  task automatic mon(input int id, input logic [3:0] c,
                     input logic [12:0] a, input logic [1:0] ba,
                     input logic k, input logic d);
    ev_t e;
    logic ev;
    ev = (k !== pc[id]) || (d !== pd[id]) || (c !== NOP);
    pc[id] = k;
    pd[id] = d;
    checks++;
    if (ba !== 2'b00) begin
      failures++;
      $display("FAIL ba_%0d cyc=%0d: got %b want 00", id, cyc, ba);
    end
    if (c === NOP) begin
      checks++;
      if (a !== 13'h0) begin
        failures++;
        $display("FAIL addr_nop_%0d cyc=%0d: got %h want 0",
                 id, cyc, a);
      end
    end
    if (ev) begin
      checks++;
      if (qsz(id) == 0) begin
        failures++;
        $display("FAIL unexp_%0d cyc=%0d: cmd=%b addr=%h cke=%b done=%b, want no event",
                 id, cyc, c, a, k, d);
      end else begin
        e = (id == 0) ? qa.pop_front() : qb.pop_front();
        if (c !== e.cmd || a !== e.addr || k !== e.cke ||
            d !== e.done || cyc != e.cyc) begin
          failures++;
          $display("FAIL evt_%0d: got cmd=%b addr=%h cke=%b done=%b cyc=%0d, want cmd=%b addr=%h cke=%b done=%b cyc=%0d",
                   id, c, a, k, d, cyc,
                   e.cmd, e.addr, e.cke, e.done, e.cyc);
        end
      end
    end
  endtask

  initial begin
    pc[0] = 1'b0; pd[0] = 1'b0;
    forever begin
      @(negedge clk);
      mon(0, bus_a.o_cmd, bus_a.o_addr, bus_a.o_ba,
          bus_a.o_cke, bus_a.o_init_done);
    end
  end

  initial begin
    pc[1] = 1'b0; pd[1] = 1'b0;
    forever begin
      @(negedge clk);
      mon(1, bus_b.o_cmd, bus_b.o_addr, bus_b.o_ba,
          bus_b.o_cke, bus_b.o_init_done);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) tick();
  endtask

  task automatic drain(input int id, input int budget);
    int n;
    n = 0;
    while (qsz(id) != 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (qsz(id) != 0) begin
      failures++;
      $display("FAIL drain_%0d: %0d events pending, want 0",
               id, qsz(id));
    end
  endtask

  // Config A: P=20 RP=2 RFC=7 N=2 MRD=2; first n events of the schedule
  task automatic sched_a(input int t0, input int n);
    if (n > 0) push(0, NOP, 13'h0,  1'b1, 1'b0, t0);
    if (n > 1) push(0, PRE, A_PALL, 1'b1, 1'b0, t0 + 20);
    if (n > 2) push(0, REF, 13'h0,  1'b1, 1'b0, t0 + 22);
    if (n > 3) push(0, REF, 13'h0,  1'b1, 1'b0, t0 + 29);
    if (n > 4) push(0, MRS, A_MODE, 1'b1, 1'b0, t0 + 36);
    if (n > 5) push(0, NOP, 13'h0,  1'b1, 1'b1, t0 + 38);
  endtask

  task automatic chk(input string nm, input logic [12:0] got,
                     input logic [12:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s cyc=%0d: got %h want %h", nm, cyc, got, want);
    end
  endtask

  initial begin
    int t0;
    rst_a = 1'b1; lock_a = 1'b0;
    rst_b = 1'b1; lock_b = 1'b0;

    // Reset hold with lock already high
    tick();
    lock_a = 1'b1;
    repeat (5) begin
      tick();
      chk("hold_cke", 13'(bus_a.o_cke), 13'h0);
      chk("hold_cmd", 13'(bus_a.o_cmd), 13'(NOP));
    end

    // Full sequence from reset release
    t0 = cyc + 3;
    sched_a(t0, 6);
    rst_a = 1'b0;
    drain(0, 60);

    // Lock loss after done is ignored
    tick();
    lock_a = 1'b0;
    repeat (10) tick();
    chk("post_done", 13'(bus_a.o_init_done), 13'h1);
    chk("post_cke", 13'(bus_a.o_cke), 13'h1);
    chk("post_cmd", 13'(bus_a.o_cmd), 13'(NOP));

    // Lock glitch during WAIT_RFC
    push(0, NOP, 13'h0, 1'b0, 1'b0, cyc);
    rst_a = 1'b1;
    lock_a = 1'b1;
    tick();
    tick();
    t0 = cyc + 3;
    sched_a(t0, 3);
    push(0, NOP, 13'h0, 1'b0, 1'b0, t0 + 26);
    rst_a = 1'b0;
    wait_cyc(t0 + 23);
    lock_a = 1'b0;
    wait_cyc(t0 + 26);
    lock_a = 1'b1;
    t0 = cyc + 3;
    sched_a(t0, 6);
    drain(0, 80);

    // Async reset in the middle of the first REF cycle
    tick();
    push(0, NOP, 13'h0, 1'b0, 1'b0, cyc);
    rst_a = 1'b1;
    tick();
    tick();
    t0 = cyc + 3;
    sched_a(t0, 2);
    push(0, NOP, 13'h0, 1'b0, 1'b0, t0 + 22);
    rst_a = 1'b0;
    wait_cyc(t0 + 22);
    chk("ref_slot", 13'(bus_a.o_cmd), 13'(REF));
    rst_a = 1'b1;
    #1;
    chk("arst_cmd", 13'(bus_a.o_cmd), 13'(NOP));
    chk("arst_cke", 13'(bus_a.o_cke), 13'h0);
    chk("arst_addr", bus_a.o_addr, 13'h0);
    tick();
    tick();
    t0 = cyc + 3;
    sched_a(t0, 6);
    rst_a = 1'b0;
    drain(0, 60);

    // Minimum delays on config B: P=5 RP=RFC=MRD=1 N=3
    tick();
    lock_b = 1'b1;
    tick();
    t0 = cyc + 3;
    push(1, NOP, 13'h0,  1'b1, 1'b0, t0);
    push(1, PRE, A_PALL, 1'b1, 1'b0, t0 + 5);
    push(1, REF, 13'h0,  1'b1, 1'b0, t0 + 6);
    push(1, REF, 13'h0,  1'b1, 1'b0, t0 + 7);
    push(1, REF, 13'h0,  1'b1, 1'b0, t0 + 8);
    push(1, MRS, A_MODE, 1'b1, 1'b0, t0 + 9);
    push(1, NOP, 13'h0,  1'b1, 1'b1, t0 + 10);
    rst_b = 1'b0;
    drain(1, 40);
    repeat (3) tick();
    chk("b_done", 13'(bus_b.o_init_done), 13'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
